// File: rtl/spram_word_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spram_word_ctrl_if
// Description : Requester A/B word ports plus segmented SRAM port for
//               spram_word_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface spram_word_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int SEG_WIDTH  = 16,
    parameter int NUM_SEGS   = 8
);
    localparam int WORD_WIDTH = SEG_WIDTH * NUM_SEGS;

    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [WORD_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_done;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [WORD_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_done;

    logic [WORD_WIDTH-1:0] rdata_word;
    logic                  busy;

    logic                  mem_wen;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [2:0]            mem_seg_sel;
    logic [SEG_WIDTH-1:0]  mem_wdata;
    logic [SEG_WIDTH-1:0]  mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_done,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_done,
        output rdata_word, busy,
        output mem_wen, mem_ren, mem_addr, mem_seg_sel, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_done,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_done,
        input  rdata_word, busy,
        input  mem_wen, mem_ren, mem_addr, mem_seg_sel, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/spram_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spram_word_ctrl
// Description : Round-robin full-word access controller over a 16b-segment
//               single-port SRAM; each word moves as 8 segment accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_word_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int SEG_WIDTH  = 16,
    parameter int NUM_SEGS   = 8
) (
    input  logic             clk,
    input  logic             rst,
    spram_word_ctrl_if.slave bus
);
    localparam int         WORD_WIDTH = SEG_WIDTH * NUM_SEGS;
    localparam logic [2:0] c_LAST_SEG = 3'(NUM_SEGS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_RDRAIN = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_seg_cnt;
    logic [2:0]            r_cap_cnt;
    logic                  r_last_gnt_b;
    logic                  r_owner_b;
    logic                  r_op_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] r_rdata_word;

    logic w_win_b;
    logic w_win_we;
    logic w_accept;
    logic w_capture;
    logic w_seg_step;

    // On a tie the requester that did not win last time takes the SRAM.
    assign w_win_b    = bus.b_req & (~bus.a_req | ~r_last_gnt_b);
    assign w_win_we   = w_win_b ? bus.b_we : bus.a_we;
    assign w_capture  = bus.mem_ready & ((r_state == S_READ) | (r_state == S_RDRAIN));
    assign w_seg_step = (r_state == S_WRITE) | (r_state == S_READ);

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.a_done     = (r_state == S_DONE) & ~r_owner_b;
    assign bus.b_done     = (r_state == S_DONE) &  r_owner_b;
    assign bus.rdata_word = r_rdata_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_seg_cnt    <= 3'd0;
            r_cap_cnt    <= 3'd0;
            r_last_gnt_b <= 1'b1;
            r_owner_b    <= 1'b0;
            r_op_we      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner_b    <= w_win_b;
                r_last_gnt_b <= w_win_b;
                r_op_we      <= w_win_we;
                r_addr       <= w_win_b ? bus.b_addr  : bus.a_addr;
                r_wdata      <= w_win_b ? bus.b_wdata : bus.a_wdata;
            end
            if (w_seg_step) begin
                r_seg_cnt <= r_seg_cnt + 3'd1;
            end
            if (w_capture) begin
                r_rdata_word[int'(r_cap_cnt) * SEG_WIDTH +: SEG_WIDTH] <= bus.mem_rdata;
                r_cap_cnt <= r_cap_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        bus.a_gnt       = 1'b0;
        bus.b_gnt       = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_seg_sel = 3'd0;
        bus.mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                // A grant during reset would be discarded, so none is given.
                if (!rst && (bus.a_req || bus.b_req)) begin
                    w_accept    = 1'b1;
                    bus.a_gnt   = ~w_win_b;
                    bus.b_gnt   = w_win_b;
                    w_state_nxt = w_win_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                bus.mem_wen     = 1'b1;
                bus.mem_addr    = r_addr;
                bus.mem_seg_sel = r_seg_cnt;
                bus.mem_wdata   = r_wdata[int'(r_seg_cnt) * SEG_WIDTH +: SEG_WIDTH];
                if (r_seg_cnt == c_LAST_SEG) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_READ: begin
                bus.mem_ren     = 1'b1;
                bus.mem_addr    = r_addr;
                bus.mem_seg_sel = r_seg_cnt;
                if (r_seg_cnt == c_LAST_SEG) begin
                    w_state_nxt = S_RDRAIN;
                end
            end
            S_RDRAIN: begin
                if (w_capture && (r_cap_cnt == c_LAST_SEG)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_word_ctrl
// Description : Self-checking bench for spram_word_ctrl with an SRAM model and
//               a transaction-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_word_ctrl;
    logic clk;
    logic rst;

    spram_word_ctrl_if #(.ADDR_WIDTH(11), .SEG_WIDTH(16), .NUM_SEGS(8)) bus ();

    spram_word_ctrl #(.ADDR_WIDTH(11), .SEG_WIDTH(16), .NUM_SEGS(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read segment SRAM: data and ready one cycle after mem_ren.
    logic [15:0] sram [0:2047][0:7];
    bit          sram_inited = 1'b0;
    always @(posedge clk) begin
        if (!sram_inited) begin
            for (int w = 0; w < 2048; w++)
                for (int s = 0; s < 8; s++)
                    sram[w][s] <= 16'h0;
            sram_inited <= 1'b1;
        end else if (bus.mem_wen) begin
            sram[bus.mem_addr][bus.mem_seg_sel] <= bus.mem_wdata;
        end
        bus.mem_ready <= bus.mem_ren;
        bus.mem_rdata <= bus.mem_ren ? sram[bus.mem_addr][bus.mem_seg_sel] : 16'h0;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic         d_rst;
    logic         d_a_req, d_a_we, d_b_req, d_b_we;
    logic [10:0]  d_a_addr, d_b_addr;
    logic [127:0] d_a_wdata, d_b_wdata;

    // Reference model: segment-level memory plus one transaction timeline.
    logic [15:0]  model_mem [0:2047][0:7];
    bit           m_active, m_owner_b, m_we, m_last_b;
    int           m_t0;
    logic [10:0]  m_addr;
    logic [127:0] m_wdata, m_exp, m_rdata_hold;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        int          d;
        logic        e_wen, e_ren, e_busy, e_agnt, e_bgnt, e_adone, e_bdone, win_b, chk_wd;
        logic [10:0] e_addr;
        logic [2:0]  e_seg;
        logic [15:0] e_wdata;
        d = cyc - m_t0;
        if (rst) begin
            // The SRAM still commits the segment presented during the reset cycle.
            if (m_active && m_we && d >= 1 && d <= 8)
                model_mem[m_addr][d-1] = m_wdata[(d-1)*16 +: 16];
            m_active     = 1'b0;
            m_last_b     = 1'b1;
            m_rdata_hold = '0;
            return;
        end
        {e_wen, e_ren, e_busy, e_agnt, e_bgnt, e_adone, e_bdone, win_b} = '0;
        e_addr = '0; e_seg = '0; e_wdata = '0; chk_wd = 1'b1;
        if (!m_active) begin
            if (bus.a_req || bus.b_req) begin
                win_b  = bus.b_req && (!bus.a_req || !m_last_b);
                e_agnt = !win_b;
                e_bgnt = win_b;
            end
        end else begin
            e_busy = 1'b1;
            if (d >= 1 && d <= 8) begin
                e_addr = m_addr;
                e_seg  = 3'(d - 1);
                if (m_we) begin
                    e_wen   = 1'b1;
                    e_wdata = m_wdata[(d-1)*16 +: 16];
                end else begin
                    e_ren  = 1'b1;
                    chk_wd = 1'b0;
                end
            end
            if (d == (m_we ? 9 : 10)) begin
                e_adone = !m_owner_b;
                e_bdone = m_owner_b;
            end
        end
        chk("a_gnt", bus.a_gnt, e_agnt);
        chk("b_gnt", bus.b_gnt, e_bgnt);
        chk("busy", bus.busy, e_busy);
        chk("mem_wen", bus.mem_wen, e_wen);
        chk("mem_ren", bus.mem_ren, e_ren);
        chk("wen_ren_exclusive", bus.mem_wen & bus.mem_ren, 1'b0);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_seg_sel", bus.mem_seg_sel, e_seg);
        if (chk_wd) chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("a_done", bus.a_done, e_adone);
        chk("b_done", bus.b_done, e_bdone);
        if (!m_active || m_we) chk("rdata_hold", bus.rdata_word, m_rdata_hold);
        if (m_active) begin
            if (m_we && d >= 1 && d <= 8)
                model_mem[m_addr][d-1] = m_wdata[(d-1)*16 +: 16];
            if (d == (m_we ? 9 : 10)) begin
                if (!m_we) begin
                    chk("rdata_word", bus.rdata_word, m_exp);
                    m_rdata_hold = m_exp;
                end
                m_active = 1'b0;
            end
        end else if (e_agnt || e_bgnt) begin
            m_active  = 1'b1;
            m_t0      = cyc;
            m_owner_b = win_b;
            m_last_b  = win_b;
            m_we      = win_b ? d_b_we    : d_a_we;
            m_addr    = win_b ? d_b_addr  : d_a_addr;
            m_wdata   = win_b ? d_b_wdata : d_a_wdata;
            if (!m_we)
                for (int s = 0; s < 8; s++) m_exp[s*16 +: 16] = model_mem[m_addr][s];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst         = d_rst;
        bus.a_req   = d_a_req;  bus.a_we = d_a_we;  bus.a_addr = d_a_addr;  bus.a_wdata = d_a_wdata;
        bus.b_req   = d_b_req;  bus.b_we = d_b_we;  bus.b_addr = d_b_addr;  bus.b_wdata = d_b_wdata;
        #3;
        cyc++;
        model_check();
    endtask

    task automatic run_until_gnt(input int max, input bit keep, output bit who_b, output int gcyc);
        bit got;
        got = 1'b0; who_b = 1'b0; gcyc = cyc;
        for (int i = 0; i < max && !got; i++) begin
            step();
            if (bus.a_gnt || bus.b_gnt) begin
                got   = 1'b1;
                who_b = bus.b_gnt;
                gcyc  = cyc;
                if (!keep) begin
                    if (bus.a_gnt) d_a_req = 1'b0;
                    else           d_b_req = 1'b0;
                end
            end
        end
        chk("gnt_timeout", got, 1'b1);
    endtask

    task automatic run_until_done(input int max, output int dcyc);
        bit got;
        got = 1'b0; dcyc = cyc;
        for (int i = 0; i < max && !got; i++) begin
            step();
            if (bus.a_done || bus.b_done) begin
                got  = 1'b1;
                dcyc = cyc;
            end
        end
        chk("done_timeout", got, 1'b1);
    endtask

    task automatic new_req(input bit is_b);
        logic [10:0]  a;
        logic [127:0] w;
        a = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 7));
        w = {$urandom, $urandom, $urandom, $urandom};
        if (is_b) begin
            d_b_req = 1'b1; d_b_we = 1'($urandom_range(0, 1)); d_b_addr = a; d_b_wdata = w;
        end else begin
            d_a_req = 1'b1; d_a_we = 1'($urandom_range(0, 1)); d_a_addr = a; d_a_wdata = w;
        end
    endtask

    typedef struct {
        bit           use_b;
        bit           we;
        logic [10:0]  addr;
        logic [127:0] wdata;
        int           exp_lat;
        bit           chk_rd;
        logic [127:0] exp_rdata;
    } vec_t;

    localparam logic [127:0] c_W0   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [127:0] c_W1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] c_WA   = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
    localparam logic [127:0] c_WR   = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [127:0] c_ONES = {128{1'b1}};

    initial begin
        vec_t vecs [8];
        bit   who;
        int   g1, g2, dc;
        bit   pa_gnt, pb_gnt, saw;

        for (int w = 0; w < 2048; w++)
            for (int s = 0; s < 8; s++) model_mem[w][s] = 16'h0;
        m_active = 0; m_last_b = 1; m_t0 = 0; m_rdata_hold = '0;
        m_owner_b = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_exp = '0;
        rst = 1'b1;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        d_rst = 1'b1;
        d_a_req = 0; d_a_we = 0; d_a_addr = '0; d_a_wdata = '0;
        d_b_req = 0; d_b_we = 0; d_b_addr = '0; d_b_wdata = '0;

        vecs[0] = '{1'b0, 1'b1, 11'd5,    c_W0,   9,  1'b0, 128'h0};
        vecs[1] = '{1'b0, 1'b0, 11'd5,    128'h0, 10, 1'b1, c_W0};
        vecs[2] = '{1'b1, 1'b1, 11'h7FF,  c_ONES, 9,  1'b0, 128'h0};
        vecs[3] = '{1'b1, 1'b0, 11'h7FF,  128'h0, 10, 1'b1, c_ONES};
        vecs[4] = '{1'b0, 1'b1, 11'd5,    c_W1,   9,  1'b0, 128'h0};
        vecs[5] = '{1'b1, 1'b0, 11'd5,    128'h0, 10, 1'b1, c_W1};
        vecs[6] = '{1'b0, 1'b0, 11'h7FF,  128'h0, 10, 1'b1, c_ONES};
        vecs[7] = '{1'b1, 1'b0, 11'd20,   128'h0, 10, 1'b1, c_WA};

        repeat (3) step();
        d_rst = 1'b0;
        step();
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_rdata", bus.rdata_word, 128'h0);

        // Tie after reset goes to A, then strict alternation.
        d_a_req = 1; d_a_we = 1; d_a_addr = 11'd20; d_a_wdata = c_WA;
        d_b_req = 1; d_b_we = 1; d_b_addr = 11'd21; d_b_wdata = c_W1;
        run_until_gnt(5, 0, who, g1);
        chk("tie1_winner_b", who, 1'b0);
        run_until_gnt(20, 0, who, g2);
        chk("tie1_second_b", who, 1'b1);
        chk("tie1_gap", g2 - g1, 10);
        d_a_req = 1; d_a_we = 1; d_a_addr = 11'd22; d_a_wdata = c_W0;
        d_b_req = 1; d_b_we = 1; d_b_addr = 11'd23; d_b_wdata = c_W0;
        run_until_gnt(20, 0, who, g1);
        chk("tie2_winner_b", who, 1'b0);
        run_until_gnt(20, 0, who, g2);
        chk("tie2_second_b", who, 1'b1);
        run_until_done(20, dc);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].use_b) begin
                d_b_req = 1; d_b_we = vecs[i].we; d_b_addr = vecs[i].addr; d_b_wdata = vecs[i].wdata;
            end else begin
                d_a_req = 1; d_a_we = vecs[i].we; d_a_addr = vecs[i].addr; d_a_wdata = vecs[i].wdata;
            end
            run_until_gnt(30, 0, who, g1);
            chk("vec_winner_b", who, vecs[i].use_b);
            run_until_done(20, dc);
            chk("vec_latency", dc - g1, vecs[i].exp_lat);
            if (vecs[i].chk_rd) chk("vec_rdata", bus.rdata_word, vecs[i].exp_rdata);
        end

        // Reset while A writes segment 3 of address 9: partial word remains.
        d_a_req = 1; d_a_we = 1; d_a_addr = 11'd9; d_a_wdata = c_WR;
        run_until_gnt(20, 0, who, g1);
        repeat (3) step();
        d_rst = 1'b1;
        step();
        d_rst = 1'b0;
        step();
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_wen", bus.mem_wen, 1'b0);
        chk("midrst_no_done", bus.a_done, 1'b0);
        saw = 1'b0;
        repeat (10) begin
            step();
            saw = saw | bus.a_done;
        end
        chk("midrst_no_late_done", saw, 1'b0);
        d_a_req = 1; d_a_we = 0; d_a_addr = 11'd9;
        run_until_gnt(20, 0, who, g1);
        run_until_done(20, dc);
        chk("midrst_partial_word", bus.rdata_word, {64'h0, c_WR[63:0]});

        // Read then write from A with req held across the grant.
        d_a_req = 1; d_a_we = 0; d_a_addr = 11'd5;
        run_until_gnt(20, 1, who, g1);
        d_a_we = 1; d_a_addr = 11'd6; d_a_wdata = c_W0;
        run_until_done(20, dc);
        chk("b2b_read_done_a", bus.a_done, 1'b1);
        chk("b2b_read_rdata", bus.rdata_word, c_W1);
        run_until_gnt(20, 0, who, g2);
        chk("b2b_gap", g2 - dc, 1);
        chk("b2b_winner_b", who, 1'b0);
        run_until_done(20, dc);

        // Randomized traffic with occasional resets, checked by the model.
        pa_gnt = 0; pb_gnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (d_rst) d_rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) d_rst = 1'b1;
            if (pa_gnt) begin
                if ($urandom_range(0, 2) == 0) new_req(1'b0); else d_a_req = 1'b0;
            end else if (!d_a_req && $urandom_range(0, 5) == 0) new_req(1'b0);
            if (pb_gnt) begin
                if ($urandom_range(0, 2) == 0) new_req(1'b1); else d_b_req = 1'b0;
            end else if (!d_b_req && $urandom_range(0, 5) == 0) new_req(1'b1);
            step();
            pa_gnt = bus.a_gnt;
            pb_gnt = bus.b_gnt;
        end
        d_rst = 1'b0; d_a_req = 1'b0; d_b_req = 1'b0;
        repeat (25) step();
        chk("final_idle", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
